mem_stage_ctrl: RTL and testbench

- MEM-stage data access controller sitting directly downstream of the EX/MEM pipeline register, in place of the single-cycle datamem.
- Consumes ALU address, store data and MemRead/MemWrite from EX/MEM; performs a handshaked access to a variable-latency backing data memory.
- Stalls the pipeline while the access is outstanding and delivers zero-extended load data to MEM/WB.
- Handles byte/half/word/double transfers with lane alignment, misalignment detection and a timeout.

---
 rtl/mem_stage_pkg.sv | 42 ++++
 rtl/mem_stage_ctrl_byte_lane_align.sv | 49 ++++
 rtl/mem_stage_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and helpers for the MEM-stage access controller.
//   state_t      : controller FSM states (IDLE, BUSY, DONE)
//   SZ_*         : legal transfer sizes in bytes
//   size_mask()  : byte-lane mask for a transfer size (0 for an illegal size)
//   align_mask() : low address bits that must be zero for a given size
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  function automatic logic [7:0] size_mask(input logic [3:0] size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      SZ_D:    m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] align_mask(input logic [3:0] size);
    logic [2:0] m;
    case (size)
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      SZ_D:    m = 3'b111;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_byte_lane_align.sv
// byte_lane_align: combinational byte-lane steering for the MEM stage.
//   off        : addr[2:0], byte offset inside the doubleword
//   size       : transfer size in bytes (1/2/4/8)
//   wdata_in   : store data, right-justified
//   rdata_in   : raw doubleword from backing memory
//   be         : byte enables, size mask shifted to the offset
//   wdata_out  : store data shifted into its byte lanes
//   rdata_out  : load data shifted down and zero-extended to size bytes
//   misaligned : offset not a multiple of size
//   size_ok    : size is one of 1/2/4/8
module byte_lane_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [2:0]        off,
  input  logic [3:0]        size,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] rdata_in,
  output logic [7:0]        be,
  output logic [DATA_W-1:0] wdata_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic              misaligned,
  output logic              size_ok
);

  localparam int LANES = DATA_W / 8;

  logic [7:0]        mask8;
  logic [LANES-1:0]  lane_mask;
  logic [DATA_W-1:0] rdata_shift;

  assign mask8       = size_mask(size);
  assign lane_mask   = LANES'(mask8);
  assign be          = mask8 << off;
  assign wdata_out   = wdata_in << {off, 3'b000};
  assign rdata_shift = rdata_in >> {off, 3'b000};
  assign size_ok     = (mask8 != 8'h00);
  assign misaligned  = ((off & align_mask(size)) != 3'b000);

  // Zero every lane above the transfer size so loads come out zero-extended.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign rdata_out[8*gi +: 8] = lane_mask[gi] ? rdata_shift[8*gi +: 8] : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller replacing a single-cycle data memory.
// Takes the EX/MEM access (addr, write_data, mem_read/mem_write, xfer_size),
// issues one handshaked request to a variable-latency backing memory, stalls
// the pipeline while it is outstanding and returns zero-extended load data.
//   clk, rst                 : clock, asynchronous active-high reset
//   addr, write_data         : access address and store data from EX/MEM
//   mem_read, mem_write      : access type from EX/MEM
//   xfer_size                : bytes per access (1/2/4/8)
//   read_data                : registered, zero-extended load result
//   stall                    : freeze upstream pipeline registers
//   err                      : sticky error (misaligned/size/rd+wr/timeout)
//   mem_req/we/addr/wdata/be : registered request to backing memory
//   mem_ack, mem_rdata       : one-cycle completion pulse and read data
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        xfer_size,
  output logic [DATA_W-1:0] read_data,
  output logic              stall,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_reg, state_next;
  logic [2:0]        off_reg;
  logic [3:0]        size_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [2:0]        lane_off;
  logic [3:0]        lane_size;
  logic [7:0]        lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;
  logic              lane_misaligned;
  logic              lane_size_ok;

  logic              access;
  logic              legal;
  logic              timeout_hit;
  logic              stall_fsm;

  // In IDLE the aligner looks at the live access (to build the request);
  // once busy it uses the latched offset/size to extract the returned data.
  assign lane_off  = (state_reg == IDLE) ? addr[2:0] : off_reg;
  assign lane_size = (state_reg == IDLE) ? xfer_size : size_reg;

  byte_lane_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .off       (lane_off),
    .size      (lane_size),
    .wdata_in  (write_data),
    .rdata_in  (mem_rdata),
    .be        (lane_be),
    .wdata_out (lane_wdata),
    .rdata_out (lane_rdata),
    .misaligned(lane_misaligned),
    .size_ok   (lane_size_ok)
  );

  assign access      = mem_read | mem_write;
  assign legal       = (mem_read ^ mem_write) & lane_size_ok & ~lane_misaligned;
  // Counter starts at 0 on the first BUSY cycle, so the last allowed cycle
  // is TIMEOUT_CYCLES-1; an ack in that cycle still wins over the timeout.
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stall_fsm  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (legal) begin
          stall_fsm  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall_fsm = 1'b1;
        if (mem_ack || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Reset must release the pipeline immediately, even before the state
  // register has been observed by the combinational decode.
  assign stall = stall_fsm & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      off_reg   <= '0;
      size_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (access) begin
            if (legal) begin
              mem_req   <= 1'b1;
              mem_we    <= mem_write;
              mem_addr  <= {addr[ADDR_W-1:3], 3'b000};
              mem_wdata <= lane_wdata;
              mem_be    <= lane_be;
              off_reg   <= addr[2:0];
              size_reg  <= xfer_size;
              cnt_reg   <= '0;
            end else begin
              err       <= 1'b1;
              read_data <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              read_data <= lane_rdata;
            end
          end else if (timeout_hit) begin
            mem_req   <= 1'b0;
            err       <= 1'b1;
            read_data <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl (TIMEOUT_CYCLES = 8): reset state,
// a table of directed accesses, a mid-access reset sequence, and randomized
// accesses checked against a byte-level reference model.
module tb_mem_stage_ctrl;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] addr, write_data, read_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, stall, err, mem_req, mem_we, mem_ack;
  logic [3:0]  xfer_size;
  logic [7:0]  mem_be;

  int tests  = 0;
  int failed = 0;

  // reference model state
  logic [63:0] m_rdata;
  logic        m_err;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .ADDR_W(64),
    .DATA_W(64),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .write_data(write_data),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .xfer_size (xfer_size),
    .read_data (read_data),
    .stall     (stall),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    bit          rst_before;
    logic        rd;
    logic        wr;
    logic [63:0] a;
    logic [63:0] wd;
    logic [3:0]  sz;
    int          ack;
    logic [63:0] rdat;
    int          e_stall;
    int          e_req;
    logic [63:0] e_addr;
    logic [63:0] e_wdata;
    logic [7:0]  e_be;
    logic        e_we;
    logic [63:0] e_read;
    logic        e_err;
  } vec_t;

  vec_t vt[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_err = 1'b0;
    m_rdata = '0;
  endtask

  // Presents one access and plays the backing memory: mem_ack is pulsed in
  // cycle ack_cyc (cycle 0 = cycle the access is presented, -1 = never).
  // Returns once the access has left the stage and the inputs are idle.
  task automatic run_access(input logic rd, input logic wr, input logic [63:0] a,
                            input logic [63:0] wd, input logic [3:0] sz,
                            input int ack_cyc, input logic [63:0] rdat,
                            output int stall_cnt, output int req_cnt,
                            output logic [63:0] c_addr, output logic [63:0] c_wdata,
                            output logic [7:0] c_be, output logic c_we,
                            output bit stable, output bit hung);
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; write_data = wd; xfer_size = sz;
    stall_cnt = 0; req_cnt = 0; stable = 1'b1; hung = 1'b1;
    c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
    for (int c = 0; c < 200; c++) begin
      mem_ack   = (c == ack_cyc);
      mem_rdata = (c == ack_cyc) ? rdat : {$urandom, $urandom};
      #1;
      if (mem_req) begin
        if (req_cnt == 0) begin
          c_addr = mem_addr; c_wdata = mem_wdata; c_be = mem_be; c_we = mem_we;
        end else if (mem_addr !== c_addr || mem_wdata !== c_wdata ||
                     mem_be !== c_be || mem_we !== c_we) begin
          stable = 1'b0;
        end
        req_cnt++;
      end
      if (!stall) begin
        hung = 1'b0;
        break;
      end
      stall_cnt++;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Reference model: expected stall length, request length and request
  // contents from the access rules, plus sticky err / load data update.
  task automatic model(input logic rd, input logic wr, input logic [63:0] a,
                       input logic [63:0] wd, input logic [3:0] sz,
                       input int ack_cyc, input logic [63:0] rdat,
                       output int e_stall, output int e_req,
                       output logic [63:0] e_addr, output logic [63:0] e_wdata,
                       output logic [7:0] e_be);
    int size;
    int off;
    bit size_ok;
    bit legal;
    logic [127:0] wide;
    logic [127:0] msk;
    size = int'(sz);
    off  = int'(a % 8);
    size_ok = (size == 1) || (size == 2) || (size == 4) || (size == 8);
    legal = (rd != wr) && size_ok && ((a % 64'(size == 0 ? 1 : size)) == 0);
    e_stall = 0; e_req = 0; e_addr = '0; e_wdata = '0; e_be = '0;
    if (!rd && !wr) return;
    if (!legal) begin
      m_err = 1'b1;
      m_rdata = '0;
      return;
    end
    e_addr  = a & ~64'h7;
    e_wdata = wd << (8 * off);
    e_be    = 8'(((1 << size) - 1) << off);
    if (ack_cyc >= 1 && ack_cyc <= T) begin
      e_stall = ack_cyc + 1;
      e_req   = ack_cyc;
      if (rd) begin
        wide = {64'h0, rdat} >> (8 * off);
        msk  = (128'h1 << (8 * size)) - 128'h1;
        m_rdata = 64'(wide & msk);
      end
    end else begin
      e_stall = T + 1;
      e_req   = T;
      m_err   = 1'b1;
      m_rdata = '0;
    end
  endtask

  initial begin
    int s_cnt, r_cnt, e_stall, e_req;
    logic [63:0] c_addr, c_wdata, e_addr, e_wdata;
    logic [7:0] c_be, e_be;
    logic c_we;
    bit stable, hung;

    //                rb rd wr  addr      wdata     sz    ack rdata                stl req e_addr    e_wdata        be     we e_read               err
    vt[0]  = '{1'b0, 1, 0, 64'h10, 64'h0,    4'd8, 1,  64'h1122334455667788, 2, 1, 64'h10, 64'h0,        8'hFF, 0, 64'h1122334455667788, 0};
    vt[1]  = '{1'b0, 0, 1, 64'h13, 64'hAB,   4'd1, 5,  64'h0,                6, 5, 64'h10, 64'hAB000000,  8'h08, 1, 64'h1122334455667788, 0};
    vt[2]  = '{1'b0, 1, 0, 64'h0E, 64'h0,    4'd2, 2,  64'hBEEF000000000000, 3, 2, 64'h08, 64'h0,        8'hC0, 0, 64'hBEEF,              0};
    vt[3]  = '{1'b0, 1, 0, 64'h20, 64'h0,    4'd4, 3,  64'hDEADBEEFCAFEF00D, 4, 3, 64'h20, 64'h0,        8'h0F, 0, 64'hCAFEF00D,          0};
    vt[4]  = '{1'b0, 0, 1, 64'h2A, 64'h1234, 4'd2, 1,  64'h0,                2, 1, 64'h28, 64'h12340000,  8'h0C, 1, 64'hCAFEF00D,          0};
    vt[5]  = '{1'b0, 1, 0, 64'h0F, 64'h0,    4'd1, 4,  64'hA500000000000000, 5, 4, 64'h08, 64'h0,        8'h80, 0, 64'hA5,                0};
    vt[6]  = '{1'b0, 1, 0, 64'h06, 64'h0,    4'd4, 1,  64'h0,                0, 0, 64'h0,  64'h0,        8'h00, 0, 64'h0,                 1};
    vt[7]  = '{1'b0, 1, 0, 64'h18, 64'h0,    4'd8, 1,  64'h0102030405060708, 2, 1, 64'h18, 64'h0,        8'hFF, 0, 64'h0102030405060708, 1};
    vt[8]  = '{1'b1, 1, 0, 64'h40, 64'h0,    4'd8, -1, 64'h0,                9, 8, 64'h40, 64'h0,        8'hFF, 0, 64'h0,                 1};
    vt[9]  = '{1'b1, 1, 1, 64'h08, 64'h0,    4'd8, 1,  64'h0,                0, 0, 64'h0,  64'h0,        8'h00, 0, 64'h0,                 1};
    vt[10] = '{1'b1, 1, 0, 64'h00, 64'h0,    4'd3, 1,  64'h0,                0, 0, 64'h0,  64'h0,        8'h00, 0, 64'h0,                 1};
    vt[11] = '{1'b1, 1, 0, 64'h30, 64'h0,    4'd8, 8,  64'h55AA55AA12345678, 9, 8, 64'h30, 64'h0,        8'hFF, 0, 64'h55AA55AA12345678, 0};
    vt[12] = '{1'b0, 1, 0, 64'h38, 64'h0,    4'd4, 9,  64'hFFFFFFFFFFFFFFFF, 9, 8, 64'h38, 64'h0,        8'h0F, 0, 64'h0,                 1};

    rst = 1'b1;
    addr = '0; write_data = '0; mem_read = 1'b0; mem_write = 1'b0;
    xfer_size = 4'd0; mem_ack = 1'b0; mem_rdata = '0;
    m_err = 1'b0; m_rdata = '0;

    // reset state
    #1;
    check("rst_read_data", read_data, 64'h0);
    check("rst_err", {63'h0, err}, 64'h0);
    check("rst_mem_req", {63'h0, mem_req}, 64'h0);
    check("rst_mem_we", {63'h0, mem_we}, 64'h0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    check("rst_mem_be", {56'h0, mem_be}, 64'h0);
    check("rst_stall", {63'h0, stall}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 13; i++) begin
      if (vt[i].rst_before) do_reset();
      run_access(vt[i].rd, vt[i].wr, vt[i].a, vt[i].wd, vt[i].sz, vt[i].ack, vt[i].rdat,
                 s_cnt, r_cnt, c_addr, c_wdata, c_be, c_we, stable, hung);
      $display("[TB] vec %0d rd=%0b wr=%0b addr=0x%0h size=%0d stall=%0d req=%0d read_data=0x%0h err=%0b",
               i, vt[i].rd, vt[i].wr, vt[i].a, vt[i].sz, s_cnt, r_cnt, read_data, err);
      check("vec_hang", {63'h0, hung}, 64'h0);
      check("vec_stall_cycles", 64'(s_cnt), 64'(vt[i].e_stall));
      check("vec_req_cycles", 64'(r_cnt), 64'(vt[i].e_req));
      if (vt[i].e_req > 0) begin
        check("vec_mem_addr", c_addr, vt[i].e_addr);
        check("vec_mem_wdata", c_wdata, vt[i].e_wdata);
        check("vec_mem_be", {56'h0, c_be}, {56'h0, vt[i].e_be});
        check("vec_mem_we", {63'h0, c_we}, {63'h0, vt[i].e_we});
        check("vec_req_stable", {63'h0, stable}, 64'h1);
      end
      check("vec_read_data", read_data, vt[i].e_read);
      check("vec_err", {63'h0, err}, {63'h0, vt[i].e_err});
      check("vec_req_idle", {63'h0, mem_req}, 64'h0);
    end

    // reset in the middle of a BUSY access, followed by a late ack
    do_reset();
    @(negedge clk);
    mem_read = 1'b1; addr = 64'h10; xfer_size = 4'd8;
    @(negedge clk);
    #1;
    check("midrst_req_before", {63'h0, mem_req}, 64'h1);
    check("midrst_stall_before", {63'h0, stall}, 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_req_now", {63'h0, mem_req}, 64'h0);
    check("midrst_stall_now", {63'h0, stall}, 64'h0);
    mem_read = 1'b0;
    mem_ack = 1'b1; mem_rdata = 64'hFFFFFFFFFFFFFFFF;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    $display("[TB] midrst req=%0b stall=%0b read_data=0x%0h err=%0b", mem_req, stall, read_data, err);
    check("midrst_req_after", {63'h0, mem_req}, 64'h0);
    check("midrst_stall_after", {63'h0, stall}, 64'h0);
    check("midrst_read_data", read_data, 64'h0);
    check("midrst_err", {63'h0, err}, 64'h0);
    m_err = 1'b0; m_rdata = '0;
    // back in IDLE: a zero-wait access must take exactly 2 stall cycles
    run_access(1'b1, 1'b0, 64'h8, 64'h0, 4'd8, 1, 64'h0BADF00D0BADF00D,
               s_cnt, r_cnt, c_addr, c_wdata, c_be, c_we, stable, hung);
    $display("[TB] post-reset access stall=%0d read_data=0x%0h", s_cnt, read_data);
    check("postrst_stall_cycles", 64'(s_cnt), 64'd2);
    check("postrst_read_data", read_data, 64'h0BADF00D0BADF00D);

    // randomized accesses against the reference model
    do_reset();
    for (int i = 0; i < 150; i++) begin
      logic rd, wr;
      logic [63:0] a, wd, rdat;
      logic [3:0] sz;
      int sel, ack;
      if (i % 25 == 24) do_reset();
      sel = $urandom_range(0, 15);
      rd = (sel >= 2 && sel < 9) || sel == 0;
      wr = (sel >= 9) || sel == 0;
      case ($urandom_range(0, 11))
        0: sz = 4'd3;
        1: sz = 4'd0;
        2, 3: sz = 4'd1;
        4, 5: sz = 4'd2;
        6, 7, 8: sz = 4'd4;
        default: sz = 4'd8;
      endcase
      a = {$urandom, $urandom};
      if ($urandom_range(0, 5) != 0) a[2:0] = a[2:0] & ~(sz[2:0] - 3'd1) & ~{sz[3], sz[3], sz[3]};
      wd = {$urandom, $urandom};
      rdat = {$urandom, $urandom};
      case ($urandom_range(0, 13))
        0: ack = -1;
        1: ack = 0;
        2: ack = T + 1;
        3: ack = T;
        default: ack = $urandom_range(1, 5);
      endcase
      model(rd, wr, a, wd, sz, ack, rdat, e_stall, e_req, e_addr, e_wdata, e_be);
      run_access(rd, wr, a, wd, sz, ack, rdat,
                 s_cnt, r_cnt, c_addr, c_wdata, c_be, c_we, stable, hung);
      $display("[TB] rnd %0d rd=%0b wr=%0b addr=0x%0h size=%0d ack=%0d stall=%0d req=%0d read_data=0x%0h err=%0b",
               i, rd, wr, a, sz, ack, s_cnt, r_cnt, read_data, err);
      check("rnd_hang", {63'h0, hung}, 64'h0);
      check("rnd_stall_cycles", 64'(s_cnt), 64'(e_stall));
      check("rnd_req_cycles", 64'(r_cnt), 64'(e_req));
      if (e_req > 0) begin
        check("rnd_mem_addr", c_addr, e_addr);
        check("rnd_mem_wdata", c_wdata, e_wdata);
        check("rnd_mem_be", {56'h0, c_be}, {56'h0, e_be});
        check("rnd_mem_we", {63'h0, c_we}, {63'h0, wr});
        check("rnd_req_stable", {63'h0, stable}, 64'h1);
      end
      check("rnd_read_data", read_data, m_rdata);
      check("rnd_err", {63'h0, err}, {63'h0, m_err});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
